vga_scanout: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_delay_line.sv | 24 ++
 rtl/vga_scanout.sv | 112 +++++++++++
 tb/tb_vga_scanout.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants and the types shared by the scanout and the framer.
package vga_timing_pkg;
   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int COLOR_W   = 3;

   typedef logic [COLOR_W-1:0] pixel_t;
   typedef logic [9:0] coord_t;

   typedef struct packed {
      logic visible;
      logic hs_n;
      logic vs_n;
      logic frame_mark;
      logic vblank_mark;
   } align_t;

   localparam align_t ALIGN_IDLE = '{visible: 1'b0, hs_n: 1'b1, vs_n: 1'b1, frame_mark: 1'b0, vblank_mark: 1'b0};
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: resettable W-bit, D-deep shift register with a per-bit reset value.
module vga_delay_line #(
   parameter int           W       = 1,
   parameter int           D       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] sr [D];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < D; i++) sr[i] <= RST_VAL;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
      end
   end

   assign q = sr[D-1];
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster timing, one frame-buffer read per visible pixel,
// and sync/RGB/frame markers aligned to the buffer's read latency.
module vga_scanout
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
   parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
   parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
   parameter int H_BACK     = vga_timing_pkg::H_BACK,
   parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
   parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
   parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
   parameter int V_BACK     = vga_timing_pkg::V_BACK,
   parameter int COLOR_W    = vga_timing_pkg::COLOR_W,
   parameter int RD_LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               fb_rd_en,
   output logic [9:0]         fb_rd_x,
   output logic [9:0]         fb_rd_y,
   input  logic [COLOR_W-1:0] fb_rd_data,
   output logic               vga_hsync,
   output logic               vga_vsync,
   output logic [COLOR_W-1:0] vga_rgb,
   output logic               frame_start,
   output logic               vblank_start
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_raster
      $error("vga_scanout: raster does not fit 10-bit counters");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
      $error("vga_scanout: RD_LATENCY must be 1..3");
   end

   localparam coord_t HV  = coord_t'(H_VISIBLE);
   localparam coord_t HS0 = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HS1 = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam coord_t HT1 = coord_t'(H_TOTAL - 1);
   localparam coord_t VV  = coord_t'(V_VISIBLE);
   localparam coord_t VS0 = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VS1 = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam coord_t VT1 = coord_t'(V_TOTAL - 1);

   coord_t h_cnt, v_cnt;
   logic   h_end, v_end, vis;
   align_t nxt, s0, al;

   assign h_end = h_cnt == HT1;
   assign v_end = v_cnt == VT1;
   assign vis   = (h_cnt < HV) && (v_cnt < VV);
   assign nxt   = '{visible:     vis,
                    hs_n:        !(h_cnt >= HS0 && h_cnt <= HS1),
                    vs_n:        !(v_cnt >= VS0 && v_cnt <= VS1),
                    frame_mark:  h_cnt == '0 && v_cnt == '0,
                    vblank_mark: h_cnt == '0 && v_cnt == VV};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= h_end ? '0 : h_cnt + 1'b1;
         if (h_end) v_cnt <= v_end ? '0 : v_cnt + 1'b1;
      end
   end

   // Stage 0: read request plus the control bundle that must track it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0      <= ALIGN_IDLE;
         fb_rd_x <= '0;
         fb_rd_y <= '0;
      end else begin
         s0      <= nxt;
         fb_rd_x <= vis ? h_cnt : '0;
         fb_rd_y <= vis ? v_cnt : '0;
      end
   end

   assign fb_rd_en = s0.visible;

   vga_delay_line #(
      .W($bits(align_t)),
      .D(RD_LATENCY),
      .RST_VAL(ALIGN_IDLE)
   ) u_align (
      .clk(clk),
      .rst_n(rst_n),
      .d(s0),
      .q(al)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_rgb      <= '0;
         vga_hsync    <= 1'b1;
         vga_vsync    <= 1'b1;
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
      end else begin
         vga_rgb      <= al.visible ? fb_rd_data : '0;
         vga_hsync    <= al.hs_n;
         vga_vsync    <= al.vs_n;
         frame_start  <= al.frame_mark;
         vblank_start <= al.vblank_mark;
      end
   end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: small-raster instances at latency 1 and 3 plus a default-raster
// instance, checked against hand-computed vectors, a position model and event timings.
module tb_vga_scanout;
   typedef struct packed {
      logic       rd;
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic [2:0] rgb;
      logic       fs;
      logic       vbs;
   } obs_t;

   typedef struct {
      int   n;
      obs_t e;
   } vec_t;

   localparam obs_t IDLE = '{rd: 1'b0, x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, rgb: 3'd0, fs: 1'b0, vbs: 1'b0};
   localparam int NT = 18;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       a_rd, b_rd, c_rd;
   logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
   logic       a_hs, a_vs, b_hs, b_vs, c_hs, c_vs;
   logic [2:0] a_rgb, b_rgb, c_rgb;
   logic       a_fs, a_vbs, b_fs, b_vbs, c_fs, c_vbs;
   logic [2:0] m_a, m_c;
   logic [2:0] m_b [3];

   // Memory models: x^y for reads, 3'b111 whenever no read is issued.
   always @(posedge clk) begin
      m_a    <= a_rd ? 3'(a_x ^ a_y) : 3'b111;
      m_c    <= c_rd ? 3'(c_x ^ c_y) : 3'b111;
      m_b[0] <= b_rd ? 3'(b_x ^ b_y) : 3'b111;
      m_b[1] <= m_b[0];
      m_b[2] <= m_b[1];
   end

   vga_scanout #(.H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                 .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .RD_LATENCY(1)) u_a (
      .clk(clk), .rst_n(rst_n), .fb_rd_en(a_rd), .fb_rd_x(a_x), .fb_rd_y(a_y),
      .fb_rd_data(m_a), .vga_hsync(a_hs), .vga_vsync(a_vs), .vga_rgb(a_rgb),
      .frame_start(a_fs), .vblank_start(a_vbs));

   vga_scanout #(.H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                 .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .RD_LATENCY(3)) u_b (
      .clk(clk), .rst_n(rst_n), .fb_rd_en(b_rd), .fb_rd_x(b_x), .fb_rd_y(b_y),
      .fb_rd_data(m_b[2]), .vga_hsync(b_hs), .vga_vsync(b_vs), .vga_rgb(b_rgb),
      .frame_start(b_fs), .vblank_start(b_vbs));

   vga_scanout u_c (
      .clk(clk), .rst_n(rst_n), .fb_rd_en(c_rd), .fb_rd_x(c_x), .fb_rd_y(c_y),
      .fb_rd_data(m_c), .vga_hsync(c_hs), .vga_vsync(c_vs), .vga_rgb(c_rgb),
      .frame_start(c_fs), .vblank_start(c_vbs));

   int   n_cmp = 0, n_bad = 0, n = 0, ti = 0;
   bit   tbl_on = 1'b0;
   vec_t tbl [NT];
   obs_t cur [3], prev [3];
   int   hf1 [3], hf2 [3], hr1 [3], fs1 [3], fs2 [3], vb1 [3], vf1 [3], vr1 [3], rdc [3];

   function automatic vec_t mk(int vn, bit rd, int x, int y, bit hs, bit vs, int rgb, bit fs, bit vbs);
      vec_t v;
      v.n = vn;
      v.e = {rd, 10'(x), 10'(y), hs, vs, 3'(rgb), fs, vbs};
      return v;
   endfunction

   // Expected pins after vn clock edges since reset release, from raster position alone.
   function automatic obs_t model(int k, int vn);
      obs_t r = IDLE;
      int hv, hf, hsw, ht, vv, vf, vsw, vt, l, p, h, v;
      if (k == 2) begin
         hv = 640; hf = 16; hsw = 96; ht = 800; vv = 480; vf = 10; vsw = 2; vt = 525;
      end else begin
         hv = 16; hf = 2; hsw = 3; ht = 23; vv = 6; vf = 1; vsw = 2; vt = 10;
      end
      l = (k == 1) ? 3 : 1;
      if (vn >= 1) begin
         p = vn - 1; h = p % ht; v = (p / ht) % vt;
         if (h < hv && v < vv) begin
            r.rd = 1'b1; r.x = 10'(h); r.y = 10'(v);
         end
      end
      if (vn >= l + 2) begin
         p = vn - l - 2; h = p % ht; v = (p / ht) % vt;
         r.hs  = !(h >= hv + hf && h < hv + hf + hsw);
         r.vs  = !(v >= vv + vf && v < vv + vf + vsw);
         r.rgb = (h < hv && v < vv) ? 3'(h ^ v) : 3'd0;
         r.fs  = h == 0 && v == 0;
         r.vbs = h == 0 && v == vv;
      end
      return r;
   endfunction

   task automatic chk(string nm, int k, obs_t got, obs_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s inst=%0d n=%0d got=%h required=%h", nm, k, n, got, exp);
      end
   endtask

   task automatic chk_int(string nm, int got, int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d required=%0d", nm, got, exp);
      end
   endtask

   task automatic sample();
      cur[0] = {a_rd, a_x, a_y, a_hs, a_vs, a_rgb, a_fs, a_vbs};
      cur[1] = {b_rd, b_x, b_y, b_hs, b_vs, b_rgb, b_fs, b_vbs};
      cur[2] = {c_rd, c_x, c_y, c_hs, c_vs, c_rgb, c_fs, c_vbs};
   endtask

   task automatic clear_events();
      for (int k = 0; k < 3; k++) begin
         hf1[k] = -1; hf2[k] = -1; hr1[k] = -1; fs1[k] = -1; fs2[k] = -1;
         vb1[k] = -1; vf1[k] = -1; vr1[k] = -1; rdc[k] = 0; prev[k] = IDLE;
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) n++;
      @(negedge clk);
      sample();
      for (int k = 0; k < 3; k++) begin
         chk("model", k, cur[k], model(k, n));
         if (rst_n) begin
            if (prev[k].hs && !cur[k].hs) begin
               if (hf1[k] < 0) hf1[k] = n; else if (hf2[k] < 0) hf2[k] = n;
            end
            if (!prev[k].hs && cur[k].hs && hf1[k] >= 0 && hr1[k] < 0) hr1[k] = n;
            if (prev[k].vs && !cur[k].vs && vf1[k] < 0) vf1[k] = n;
            if (!prev[k].vs && cur[k].vs && vf1[k] >= 0 && vr1[k] < 0) vr1[k] = n;
            if (cur[k].fs) begin
               if (fs1[k] < 0) fs1[k] = n; else if (fs2[k] < 0) fs2[k] = n;
            end
            if (cur[k].vbs && vb1[k] < 0) vb1[k] = n;
            if (cur[k].rd && n <= 230) rdc[k]++;
         end
         prev[k] = cur[k];
      end
      if (tbl_on && ti < NT && tbl[ti].n == n) begin
         chk("table", 0, cur[0], tbl[ti].e);
         ti++;
      end
   endtask

   initial begin
      tbl[0]  = mk(1,   1, 0, 0, 1, 1, 0, 0, 0);
      tbl[1]  = mk(2,   1, 1, 0, 1, 1, 0, 0, 0);
      tbl[2]  = mk(3,   1, 2, 0, 1, 1, 0, 1, 0);
      tbl[3]  = mk(4,   1, 3, 0, 1, 1, 1, 0, 0);
      tbl[4]  = mk(17,  0, 0, 0, 1, 1, 6, 0, 0);
      tbl[5]  = mk(21,  0, 0, 0, 0, 1, 0, 0, 0);
      tbl[6]  = mk(23,  0, 0, 0, 0, 1, 0, 0, 0);
      tbl[7]  = mk(24,  1, 0, 1, 1, 1, 0, 0, 0);
      tbl[8]  = mk(31,  1, 7, 1, 1, 1, 4, 0, 0);
      tbl[9]  = mk(131, 1, 15, 5, 1, 1, 0, 0, 0);
      tbl[10] = mk(132, 0, 0, 0, 1, 1, 3, 0, 0);
      tbl[11] = mk(141, 0, 0, 0, 1, 1, 0, 0, 1);
      tbl[12] = mk(164, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[13] = mk(209, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[14] = mk(210, 0, 0, 0, 1, 1, 0, 0, 0);
      tbl[15] = mk(230, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[16] = mk(233, 1, 2, 0, 1, 1, 0, 1, 0);
      tbl[17] = mk(234, 1, 3, 0, 1, 1, 1, 0, 0);
      clear_events();
      repeat (3) step();
      rst_n  = 1'b1;
      tbl_on = 1'b1;
      while (n < 1919) step();
      tbl_on = 1'b0;
      chk_int("table_hits", ti, NT);
      chk_int("a_hs_fall", hf1[0], 21);
      chk_int("a_hs_width", hr1[0] - hf1[0], 3);
      chk_int("a_line_period", hf2[0] - hf1[0], 23);
      chk_int("b_hs_fall", hf1[1], 23);
      chk_int("b_hs_width", hr1[1] - hf1[1], 3);
      chk_int("b_line_period", hf2[1] - hf1[1], 23);
      chk_int("c_hs_fall", hf1[2], 659);
      chk_int("c_hs_width", hr1[2] - hf1[2], 96);
      chk_int("c_line_period", hf2[2] - hf1[2], 800);
      chk_int("a_fs_first", fs1[0], 3);
      chk_int("a_fs_period", fs2[0] - fs1[0], 230);
      chk_int("a_vbs_offset", vb1[0] - fs1[0], 138);
      chk_int("a_vs_offset", vf1[0] - fs1[0], 161);
      chk_int("a_vs_width", vr1[0] - vf1[0], 46);
      chk_int("a_reads_frame", rdc[0], 96);
      chk_int("b_fs_first", fs1[1], 5);
      chk_int("b_fs_period", fs2[1] - fs1[1], 230);
      chk_int("b_vbs_offset", vb1[1] - fs1[1], 138);
      chk_int("b_reads_frame", rdc[1], 96);
      chk_int("c_fs_first", fs1[2], 3);
      // Mid-frame reset while instance a shows a visible pixel; pins must drop at once.
      rst_n = 1'b0;
      #1;
      sample();
      for (int k = 0; k < 3; k++) chk("async_rst", k, cur[k], IDLE);
      n = 0;
      clear_events();
      repeat (3) step();
      rst_n = 1'b1;
      repeat (300) step();
      chk_int("a_fs_after_rst", fs1[0], 3);
      chk_int("b_fs_after_rst", fs1[1], 5);
      chk_int("c_fs_after_rst", fs1[2], 3);
      chk_int("a_fs_period_after_rst", fs2[0] - fs1[0], 230);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
